// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and constants for the UART transmit path.
package uart_pkg;
  localparam int BYTE_W    = 8;
  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 115_200;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, HOLD} arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the uart_tx start/busy handshake.
interface uart_tx_arbiter_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0]                  req;
  logic [uart_pkg::BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]                  req_last;
  logic [N_REQ-1:0]                  req_ack;
  logic [uart_pkg::BYTE_W-1:0]       tx_data;
  logic                              tx_start;
  logic                              tx_busy;
  modport master (output req, req_data, req_last, tx_busy, input req_ack, tx_data, tx_start);
  modport slave  (input req, req_data, req_last, tx_busy, output req_ack, tx_data, tx_start);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: first set request after the pointer, wrapping at N_REQ-1.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // Walk from farthest to nearest so the nearest set request overwrites last.
  always_comb begin
    idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % N_REQ]) idx = IDX_W'((int'(ptr) + k) % N_REQ);
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx among N_REQ byte streams.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N_REQ   = 2,
  parameter int IDX_W   = 1,
  parameter int BUSY_TO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [IDX_W-1:0] grant_id,
  output logic             locked,
  output logic             err_busy_to
);
  localparam int CNT_W = $clog2(BUSY_TO + 1);
  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d, rr_q, rr_d, winner;
  logic               locked_q, locked_d, last_q, last_d, err_q, err_d, any;
  logic               tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(bus.req), .ptr(rr_q), .idx(winner), .any(any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    locked_d   = locked_q;
    last_d     = last_q;
    err_d      = err_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    req_ack_d  = '0;
    case (state_q)
      IDLE: if (any) begin
        grant_d  = winner;
        locked_d = 1'b1;
        state_d  = SEND;
      end
      // A withdrawn request keeps the lock and waits in HOLD rather than acking nothing.
      SEND: if (!bus.tx_busy) begin
        if (bus.req[grant_q]) begin
          tx_data_d          = bus.req_data[BYTE_W*grant_q +: BYTE_W];
          tx_start_d         = 1'b1;
          req_ack_d[grant_q] = 1'b1;
          last_d             = bus.req_last[grant_q];
          cnt_d              = '0;
          state_d            = WAIT_HI;
        end else state_d = HOLD;
      end
      WAIT_HI: if (bus.tx_busy) state_d = WAIT_LO;
        else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = WAIT_LO;
        end else cnt_d = cnt_q + 1'b1;
      WAIT_LO: if (!bus.tx_busy) begin
        if (last_q) begin
          rr_d     = grant_q;
          locked_d = 1'b0;
          state_d  = IDLE;
        end else state_d = HOLD;
      end
      HOLD: state_d = bus.req[grant_q] ? SEND : HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= IDX_W'(N_REQ - 1);
      locked_q   <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      req_ack_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      locked_q   <= locked_d;
      last_q     <= last_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      req_ack_q  <= req_ack_d;
      cnt_q      <= cnt_d;
    end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.req_ack  = req_ack_q;
  assign grant_id     = grant_q;
  assign locked       = locked_q;
  assign err_busy_to  = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a uart_tx busy model and two requester drivers.
module tb_uart_tx_arbiter;
  localparam int N = 2;
  localparam int BUSY_TO = 16;
  localparam int FRAME = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:0] grant_id;
  logic locked, err;
  int tests = 0;
  int fails = 0;
  int n_start = 0;
  int bcnt;
  bit model_en = 1'b1;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int ord_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .IDX_W(1), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant_id(grant_id), .locked(locked), .err_busy_to(err)
  );

  // uart_tx stand-in: busy rises the cycle after tx_start and lasts FRAME cycles.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (bus.tx_start && model_en) bcnt <= FRAME;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  assign bus.tx_busy = (bcnt > 0);

  task automatic monitor();
    logic [7:0] e;
    int o;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_start) begin
        n_start++;
        tests++;
        if ((grant_id == 1'b0 ? exp0.size() : exp1.size()) == 0) begin
          fails++;
          $display("FAIL unexpected_start: grant %0d data %h, no byte expected", grant_id, bus.tx_data);
        end else begin
          e = (grant_id == 1'b0) ? exp0.pop_front() : exp1.pop_front();
          if (bus.tx_data !== e) begin
            fails++;
            $display("FAIL tx_data: got %h exp %h", bus.tx_data, e);
          end
        end
        tests++;
        if (bus.req_ack !== (2'b01 << grant_id)) begin
          fails++;
          $display("FAIL req_ack: got %b exp %b", bus.req_ack, 2'b01 << grant_id);
        end
        if (ord_q.size() > 0) begin
          o = ord_q.pop_front();
          tests++;
          if (int'(grant_id) != o) begin
            fails++;
            $display("FAIL grant_order: got %0d exp %0d", grant_id, o);
          end
        end
      end
    end
  endtask

  task automatic send_byte(input int id, input logic [7:0] d, input logic last);
    bus.req_data[8*id +: 8] = d;
    bus.req_last[id] = last;
    bus.req[id] = 1'b1;
    if (id == 0) exp0.push_back(d); else exp1.push_back(d);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.req_ack[id]) break;
    end
    tests++;
    if (bus.req_ack[id] !== 1'b1) begin
      fails++;
      $display("FAIL ack_timeout: req %0d byte %h ack %b exp 1", id, d, bus.req_ack[id]);
    end
    bus.req[id] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!locked && !bus.tx_busy) break;
    end
    tests++;
    if (locked !== 1'b0 || bus.tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: locked %b busy %b exp 0 0", nm, locked, bus.tx_busy);
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    ord_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    do_reset();
    tests++;
    if ({bus.tx_start, bus.req_ack, bus.tx_data, grant_id, locked, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h exp 0", {bus.tx_start, bus.req_ack, bus.tx_data, grant_id, locked, err});
    end
    repeat (100) begin
      @(negedge clk);
      if ({bus.tx_start, bus.req_ack, bus.tx_data, grant_id, locked, err} !== '0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL idle_100: outputs got nonzero exp 0");
    end
  endtask

  task automatic test_packet();
    int s0 = n_start;
    logic [7:0] bytes [3] = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) begin
      ord_q.push_back(0);
      send_byte(0, bytes[i], i == 2);
    end
    for (int c = 0; c < 50 && !bus.tx_busy; c++) @(negedge clk);
    for (int c = 0; c < 50 && bus.tx_busy; c++) @(negedge clk);
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL locked_last_busy_low: got %b exp 1", locked);
    end
    @(negedge clk);
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL locked_release: got %b exp 0", locked);
    end
    tests++;
    if (n_start - s0 != 3) begin
      fails++;
      $display("FAIL packet_starts: got %0d exp 3", n_start - s0);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    repeat (2) begin
      ord_q.push_back(0);
      ord_q.push_back(1);
      fork
        send_byte(0, 8'hAA, 1'b1);
        send_byte(1, 8'h55, 1'b1);
      join
      wait_idle("rr");
    end
  endtask

  task automatic test_lock_hold();
    ord_q.push_back(0);
    ord_q.push_back(0);
    ord_q.push_back(1);
    fork
      begin
        send_byte(0, 8'h10, 1'b0);
        repeat (50) @(negedge clk);
        send_byte(0, 8'h11, 1'b1);
      end
      begin
        repeat (5) @(negedge clk);
        send_byte(1, 8'h20, 1'b1);
      end
      begin
        repeat (30) @(negedge clk);
        tests++;
        if (grant_id !== 1'b0 || locked !== 1'b1 || bus.req_ack !== 2'b00) begin
          fails++;
          $display("FAIL lock_stall: grant %0d locked %b ack %b exp 0 1 00", grant_id, locked, bus.req_ack);
        end
      end
    join
    wait_idle("lock");
  endtask

  task automatic test_busy_timeout();
    int seen = -1;
    model_en = 1'b0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_before: got %b exp 0", err);
    end
    send_byte(0, 8'h77, 1'b1);
    for (int k = 1; k <= BUSY_TO + 4; k++) begin
      @(negedge clk);
      if (err === 1'b1 && seen < 0) seen = k;
    end
    tests++;
    if (seen != BUSY_TO) begin
      fails++;
      $display("FAIL timeout_cycle: got %0d exp %0d", seen, BUSY_TO);
    end
    tests++;
    if (locked !== 1'b0 || err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_return: locked %b err %b exp 0 1", locked, err);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    send_byte(0, 8'h3C, 1'b1);
    for (int c = 0; c < 20 && !bus.tx_busy; c++) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.tx_start, bus.req_ack, bus.tx_data, grant_id, locked, err} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h exp 0", {bus.tx_start, bus.req_ack, bus.tx_data, grant_id, locked, err});
    end
    exp0.delete();
    ord_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ord_q.push_back(0);
    send_byte(0, 8'h5A, 1'b1);
    wait_idle("post_reset");
    tests++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      fails++;
      $display("FAIL leftover_bytes: got %0d exp 0", exp0.size() + exp1.size());
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_packet();
    test_round_robin();
    test_lock_hold();
    test_busy_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
